highscore_table: RTL and testbench



---
 rtl/highscore_table.sv | 153 +++++++++++++++
 tb/tb_highscore_table.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/highscore_table.sv
// Score keeper and sorted high-score table for the Snake game, with a
// multi-cycle double-dabble converter driving the selected value as packed BCD.
module highscore_table #(
  parameter int SCORE_W = 11,
  parameter int DEPTH   = 3,
  parameter int SEL_W   = 2,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  increment,
  input  logic                  commit,
  input  logic                  new_game,
  input  logic [SEL_W-1:0]      sel,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic [SEL_W-1:0]      rank,
  output logic                  new_high,
  output logic [1:0]            o_dbg_state
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  typedef enum logic {PLAYING = 1'b0, LOCKED = 1'b1} score_state_t;
  typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} conv_state_t;

  score_state_t r_score_state, w_score_state_nxt;
  conv_state_t  r_conv_state, w_conv_state_nxt;

  logic [SCORE_W-1:0]  r_score, w_score_nxt;
  logic [SCORE_W-1:0]  r_table [DEPTH];
  logic                w_place, w_do_insert;
  logic [SEL_W-1:0]    w_ins_idx;

  logic [SCORE_W-1:0]  w_sel_val, r_snap, r_shift;
  logic [4*DIGITS-1:0] r_bcd, r_bcd_out, w_adj, w_bcd_step;
  logic [CNT_W-1:0]    r_step;
  logic                w_start, w_last;

  // Lowest table position the current score beats; ties rank below.
  always_comb begin
    w_place   = 1'b0;
    w_ins_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_score > r_table[i]) begin
        w_place   = 1'b1;
        w_ins_idx = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_score_state <= PLAYING;
    else      r_score_state <= w_score_state_nxt;
  end

  always_comb begin
    w_score_state_nxt = r_score_state;
    w_score_nxt       = r_score;
    w_do_insert       = 1'b0;
    if (new_game) begin
      w_score_state_nxt = PLAYING;
      w_score_nxt       = '0;
    end else if (r_score_state == PLAYING) begin
      if (commit) begin
        w_score_state_nxt = LOCKED;
        w_do_insert       = w_place;
      end else if (increment && (r_score != SCORE_MAX)) begin
        w_score_nxt = r_score + SCORE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_score <= '0;
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
    end else begin
      r_score <= w_score_nxt;
      if (w_do_insert) begin
        for (int i = DEPTH - 1; i >= 1; i--) begin
          if (SEL_W'(i) > w_ins_idx) r_table[i] <= r_table[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (SEL_W'(i) == w_ins_idx) r_table[i] <= r_score;
        end
      end
    end
  end

  assign rank     = (r_score_state == PLAYING && w_place) ? (w_ins_idx + SEL_W'(1)) : '0;
  assign new_high = (r_score_state == PLAYING) && (r_score > r_table[0]);

  always_comb begin
    w_sel_val = '0;
    if (sel == '0) begin
      w_sel_val = r_score;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sel == SEL_W'(i + 1)) w_sel_val = r_table[i];
      end
    end
  end

  // One double-dabble step: add 3 to digits >= 5, then shift in the next bit.
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
    w_bcd_step = {w_adj[4*DIGITS-2:0], r_shift[SCORE_W-1]};
  end

  assign w_start = (r_conv_state == IDLE) && (w_sel_val != r_snap);
  assign w_last  = (r_conv_state == CONVERT) && (r_step == CNT_W'(SCORE_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_conv_state <= IDLE;
    else      r_conv_state <= w_conv_state_nxt;
  end

  always_comb begin
    w_conv_state_nxt = r_conv_state;
    if (w_start)     w_conv_state_nxt = CONVERT;
    else if (w_last) w_conv_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap    <= '0;
      r_shift   <= '0;
      r_bcd     <= '0;
      r_step    <= '0;
      r_bcd_out <= '0;
    end else if (w_start) begin
      r_snap  <= w_sel_val;
      r_shift <= w_sel_val;
      r_bcd   <= '0;
      r_step  <= '0;
    end else if (r_conv_state == CONVERT) begin
      r_bcd   <= w_bcd_step;
      r_shift <= {r_shift[SCORE_W-2:0], 1'b0};
      r_step  <= r_step + CNT_W'(1);
      if (w_last) r_bcd_out <= w_bcd_step;
    end
  end

  assign bcd_out     = r_bcd_out;
  assign bcd_valid   = (r_conv_state == IDLE) && (w_sel_val == r_snap);
  assign o_dbg_state = {r_conv_state, r_score_state};

endmodule

// File: tb/tb_highscore_table.sv
// Directed plus randomized bench for highscore_table; expected values come from a
// sorted-list model of the game and a decimal conversion of the selected value.
module tb_highscore_table;

  localparam int SCORE_W = 11;
  localparam int DEPTH   = 3;
  localparam int SEL_W   = 2;
  localparam int DIGITS  = 4;
  localparam int MAXV    = (1 << SCORE_W) - 1;
  localparam int LAT     = SCORE_W + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                increment = 1'b0;
  logic                commit = 1'b0;
  logic                new_game = 1'b0;
  logic [SEL_W-1:0]    sel = '0;
  logic [4*DIGITS-1:0] bcd_out;
  logic                bcd_valid;
  logic [SEL_W-1:0]    rank;
  logic                new_high;
  logic [1:0]          o_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  int m_score  = 0;
  bit m_locked = 0;
  int m_tab [DEPTH];

  highscore_table #(.SCORE_W(SCORE_W), .DEPTH(DEPTH), .SEL_W(SEL_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .increment(increment), .commit(commit), .new_game(new_game),
    .sel(sel), .bcd_out(bcd_out), .bcd_valid(bcd_valid), .rank(rank),
    .new_high(new_high), .o_dbg_state(o_dbg_state)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int exp_sel(input int s);
    if (s == 0) return m_score;
    if (s <= DEPTH) return m_tab[s-1];
    return 0;
  endfunction

  // Table is always the DEPTH largest values seen so far (zeros fill the rest).
  task automatic model_insert(input int v);
    int q[$];
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(m_tab[i]);
    q.push_back(v);
    q.rsort();
    for (int i = 0; i < DEPTH; i++) m_tab[i] = q[i];
  endtask

  function automatic int exp_rank();
    int ahead;
    if (m_locked || m_score == 0) return 0;
    ahead = 0;
    for (int i = 0; i < DEPTH; i++) if (m_tab[i] >= m_score) ahead++;
    return (ahead < DEPTH) ? ahead + 1 : 0;
  endfunction

  task automatic model_step(input logic inc, input logic com, input logic ng);
    if (ng) begin
      m_score  = 0;
      m_locked = 0;
    end else if (!m_locked) begin
      if (com) begin
        model_insert(m_score);
        m_locked = 1;
      end else if (inc && m_score < MAXV) begin
        m_score++;
      end
    end
  endtask

  task automatic model_reset();
    m_score  = 0;
    m_locked = 0;
    for (int i = 0; i < DEPTH; i++) m_tab[i] = 0;
  endtask

  task automatic check_status();
    chk("rank", rank, exp_rank());
    chk("new_high", new_high, (!m_locked && m_score > m_tab[0]) ? 1 : 0);
    chk("locked", o_dbg_state[0], m_locked);
  endtask

  // Called at a negedge; applies strobes for one rising edge, checks at the next negedge.
  task automatic cycle(input logic inc, input logic com, input logic ng);
    increment = inc;
    commit    = com;
    new_game  = ng;
    @(posedge clk);
    model_step(inc, com, ng);
    @(negedge clk);
    increment = 1'b0;
    commit    = 1'b0;
    new_game  = 1'b0;
    check_status();
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 60; k++) begin
      if (bcd_valid === 1'b1) break;
      @(posedge clk);
      @(negedge clk);
    end
    chk({tag, "_valid_timeout"}, bcd_valid, 1);
  endtask

  task automatic check_sel(input int s);
    sel = SEL_W'(s);
    #1;
    wait_valid($sformatf("sel%0d", s));
    chk($sformatf("bcd_sel%0d", s), bcd_out, to_bcd(exp_sel(s)));
  endtask

  task automatic play(input int s);
    cycle(0, 0, 1);
    for (int i = 0; i < s; i++) cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 1);
  endtask

  int k;

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_bcd_out", bcd_out, 0);
    chk("rst_bcd_valid", bcd_valid, 1);
    chk("rst_rank", rank, 0);
    chk("rst_new_high", new_high, 0);
    chk("rst_dbg_state", o_dbg_state, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single pulse: valid drops, then returns exactly LAT edges later.
    cycle(1, 0, 0);
    chk("lat1_valid_low", bcd_valid, 0);
    k = 0;
    while (bcd_valid !== 1'b1 && k < 40) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    chk("lat1_cycles", k, LAT);
    chk("lat1_bcd", bcd_out, 16'h0001);

    for (int i = 0; i < 4; i++) cycle(1, 0, 0);
    wait_valid("five");
    chk("five_bcd", bcd_out, 16'h0005);
    chk("five_rank", rank, 1);
    chk("five_new_high", new_high, 1);

    // Selection change: latency measured from the sel update.
    check_sel(1);
    sel = '0;
    #1;
    chk("lat2_valid_low", bcd_valid, 0);
    k = 0;
    while (bcd_valid !== 1'b1 && k < 40) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    chk("lat2_cycles", k, LAT);
    chk("lat2_bcd", bcd_out, 16'h0005);

    play(7);
    play(12);
    play(9);
    play(3);
    check_sel(1);
    chk("games_top", bcd_out, 16'h0012);
    check_sel(2);
    check_sel(3);
    chk("games_third", bcd_out, 16'h0007);

    // Tie with an existing 9 places below it.
    cycle(0, 0, 1);
    for (int i = 0; i < 9; i++) cycle(1, 0, 0);
    chk("tie_rank_before", rank, 3);
    cycle(0, 1, 0);
    check_sel(2);
    check_sel(3);
    chk("tie_third", bcd_out, 16'h0009);

    // Saturation.
    cycle(0, 0, 1);
    for (int i = 0; i < 2050; i++) cycle(1, 0, 0);
    check_sel(0);
    chk("sat_bcd", bcd_out, 16'h2047);

    // Reset in the middle of a conversion.
    cycle(0, 0, 1);
    wait_valid("pre_rst");
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    sel = SEL_W'(1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0);
      chk("midconv_valid_low", bcd_valid, 0);
    end
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_bcd_out", bcd_out, 0);
    chk("arst_bcd_valid", bcd_valid, 1);
    chk("arst_rank", rank, 0);
    chk("arst_new_high", new_high, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int s = 1; s <= DEPTH; s++) check_sel(s);

    // commit + increment together, then commit again while locked.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    chk("ci_rank", rank, 0);
    check_sel(0);
    chk("ci_score", bcd_out, 16'h0004);
    check_sel(1);
    chk("ci_tab1", bcd_out, 16'h0004);
    check_sel(2);
    chk("ci_tab2", bcd_out, 16'h0000);

    // Randomized play with periodic readback of every selection.
    for (int blk = 0; blk < 8; blk++) begin
      for (int c = 0; c < 60; c++) begin
        cycle(logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 15) == 0),
              logic'($urandom_range(0, 31) == 0));
      end
      for (int s = 0; s <= DEPTH; s++) check_sel(s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
